// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM states and
// EX-stage forwarding selects, plus the per-operand forwarding rule.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // The memory stage holds the younger result, so it beats writeback.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs_e,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            return FWD_MEM;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Purely combinational EX-stage operand forwarding selects.
module forward_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_en_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_en_w,
    output logic [1:0] forward_a_e,
    output logic [1:0] forward_b_e
);

    assign forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_en_m, rd_w, reg_write_en_w);
    assign forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_en_m, rd_w, reg_write_en_w);

endmodule

// File: rtl/hazard_controller.sv
// Five-stage pipeline sequencer: load-use stalls, decode redirects, memory
// ready handshake with timeout watchdog, forwarding selects, stall counter.
module hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             MemReadEnE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteEnM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteEnW,
    input  logic             PCSrcD,
    input  logic             DMemReqM,
    input  logic             DMemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int unsigned WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int unsigned EXPIRE_AT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [WAIT_W-1:0] EXPIRE_CNT = WAIT_W'(EXPIRE_AT);

    hz_state_e          state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic       req_pend;
    logic       expire;
    logic       mem_stall;
    logic       load_use;
    logic [1:0] fwd_a, fwd_b;

    assign req_pend  = DMemReqM && !DMemReadyM;
    assign expire    = (MEM_TIMEOUT != 0) && req_pend && (wait_cnt_q == EXPIRE_CNT);
    assign mem_stall = req_pend || (state_q == ERROR);
    assign load_use  = MemReadEnE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else if (PCSrcD) begin
                FlushD = 1'b1;
            end
        end
    end

    forward_unit u_forward_unit (
        .rs1_e          (Rs1E),
        .rs2_e          (Rs2E),
        .rd_m           (RdM),
        .reg_write_en_m (RegWriteEnM),
        .rd_w           (RdW),
        .reg_write_en_w (RegWriteEnW),
        .forward_a_e    (fwd_a),
        .forward_b_e    (fwd_b)
    );

    assign ForwardAE = rst ? fwd_a : FWD_RF;
    assign ForwardBE = rst ? fwd_b : FWD_RF;

    // Ready arriving in the expiry cycle clears req_pend, so it beats the timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (expire)        state_d = ERROR;
                else if (req_pend) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (DMemReadyM)    state_d = RUN;
                else if (expire)   state_d = ERROR;
            end
            ERROR:   state_d = ERROR;
            default: state_d = RUN;
        endcase

        mem_err_d = mem_err_q || (state_d == ERROR);

        wait_cnt_d = '0;
        if (req_pend) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        end

        stall_cycles_d = stall_cycles_q;
        if (StallF && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign MemErr      = mem_err_q;
    assign StallCycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller with hand-computed expectations;
// small timeout and counter width so watchdog and saturation are reachable.
module tb_hazard_controller;
    import pipeline_ctrl_pkg::*;

    localparam logic [6:0] CTL_NONE = 7'b000_0000;
    localparam logic [6:0] CTL_LU   = 7'b110_0010;
    localparam logic [6:0] CTL_BR   = 7'b000_0100;
    localparam logic [6:0] CTL_MEM  = 7'b111_1001;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       mem_read_en_e, reg_write_en_m, reg_write_en_w;
    logic       pc_src_d, dmem_req_m, dmem_ready_m;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;
    logic [1:0] forward_a_e, forward_b_e;
    logic       mem_err;
    logic [3:0] stall_cycles;
    logic [6:0] ctl;

    int n_vec    = 0;
    int n_miscmp = 0;

    assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

    hazard_controller #(
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Rs1D        (rs1_d),
        .Rs2D        (rs2_d),
        .Rs1E        (rs1_e),
        .Rs2E        (rs2_e),
        .RdE         (rd_e),
        .MemReadEnE  (mem_read_en_e),
        .RdM         (rd_m),
        .RegWriteEnM (reg_write_en_m),
        .RdW         (rd_w),
        .RegWriteEnW (reg_write_en_w),
        .PCSrcD      (pc_src_d),
        .DMemReqM    (dmem_req_m),
        .DMemReadyM  (dmem_ready_m),
        .StallF      (stall_f),
        .StallD      (stall_d),
        .StallE      (stall_e),
        .StallM      (stall_m),
        .FlushD      (flush_d),
        .FlushE      (flush_e),
        .FlushW      (flush_w),
        .ForwardAE   (forward_a_e),
        .ForwardBE   (forward_b_e),
        .MemErr      (mem_err),
        .StallCycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
        rd_e = '0; rd_m = '0; rd_w = '0;
        mem_read_en_e = 1'b0; reg_write_en_m = 1'b0; reg_write_en_w = 1'b0;
        pc_src_d = 1'b0; dmem_req_m = 1'b0; dmem_ready_m = 1'b0;
    endtask

    // Returns at a negedge with reset released and inputs cleared.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        // Reset with inputs that would otherwise raise every output.
        mem_read_en_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
        reg_write_en_m = 1'b1; rd_m = 5'd3; rs1_e = 5'd3;
        pc_src_d = 1'b1; dmem_req_m = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("reset_ctl", 32'(ctl), 32'(CTL_NONE));
        check("reset_fwd_a", 32'(forward_a_e), 32'(FWD_RF));
        check("reset_memerr", 32'(mem_err), 32'd0);
        check("reset_count", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;

        // Load-use on rs1.
        mem_read_en_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
        #1;
        check("lu_rs1_ctl", 32'(ctl), 32'(CTL_LU));
        check("lu_count_before", 32'(stall_cycles), 32'd0);
        @(posedge clk); #1;
        check("lu_count_after", 32'(stall_cycles), 32'd1);
        @(negedge clk); clear_inputs(); #1;
        check("lu_gone_ctl", 32'(ctl), 32'(CTL_NONE));

        @(negedge clk); mem_read_en_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0; #1;
        check("lu_x0_ctl", 32'(ctl), 32'(CTL_NONE));
        @(negedge clk); rd_e = 5'd9; rs1_d = 5'd1; rs2_d = 5'd9; #1;
        check("lu_rs2_ctl", 32'(ctl), 32'(CTL_LU));
        @(negedge clk); mem_read_en_e = 1'b0; #1;
        check("no_load_ctl", 32'(ctl), 32'(CTL_NONE));
        @(negedge clk); mem_read_en_e = 1'b1; pc_src_d = 1'b1; #1;
        check("lu_branch_ctl", 32'(ctl), 32'(CTL_LU));
        @(negedge clk); clear_inputs(); pc_src_d = 1'b1; #1;
        check("branch_ctl", 32'(ctl), 32'(CTL_BR));

        // Forwarding priority.
        @(negedge clk); clear_inputs();
        rd_m = 5'd7; rd_w = 5'd7; rs1_e = 5'd7;
        reg_write_en_m = 1'b1; reg_write_en_w = 1'b1; #1;
        check("fwd_a_mem", 32'(forward_a_e), 32'(FWD_MEM));
        @(negedge clk); reg_write_en_m = 1'b0; #1;
        check("fwd_a_wb", 32'(forward_a_e), 32'(FWD_WB));
        @(negedge clk); rs1_e = 5'd0; #1;
        check("fwd_a_rf", 32'(forward_a_e), 32'(FWD_RF));
        @(negedge clk); rd_m = 5'd0; reg_write_en_m = 1'b1; rd_w = 5'd0; #1;
        check("fwd_a_x0", 32'(forward_a_e), 32'(FWD_RF));
        @(negedge clk); rs2_e = 5'd4; rd_w = 5'd4; rd_m = 5'd6; #1;
        check("fwd_b_wb", 32'(forward_b_e), 32'(FWD_WB));
        @(negedge clk); rd_m = 5'd4; #1;
        check("fwd_b_mem", 32'(forward_b_e), 32'(FWD_MEM));

        // Three not-ready cycles, ready in the fourth (also the expiry cycle).
        do_reset();
        dmem_req_m = 1'b1; dmem_ready_m = 1'b0; #1;
        check("mw_c1_ctl", 32'(ctl), 32'(CTL_MEM));
        @(posedge clk); #1;
        check("mw_state_wait", 32'(dut.state_q), 32'(MEM_WAIT));
        @(negedge clk);
        pc_src_d = 1'b1; mem_read_en_e = 1'b1; rd_e = 5'd2; rs1_d = 5'd2;
        reg_write_en_m = 1'b1; rd_m = 5'd7; rs1_e = 5'd7; #1;
        check("mw_c2_ctl", 32'(ctl), 32'(CTL_MEM));
        check("mw_c2_fwd_a", 32'(forward_a_e), 32'(FWD_MEM));
        @(negedge clk); pc_src_d = 1'b0; mem_read_en_e = 1'b0; #1;
        check("mw_c3_ctl", 32'(ctl), 32'(CTL_MEM));
        @(negedge clk); dmem_ready_m = 1'b1; #1;
        check("mw_ready_ctl", 32'(ctl), 32'(CTL_NONE));
        @(posedge clk); #1;
        check("mw_state_run", 32'(dut.state_q), 32'(RUN));
        check("mw_memerr", 32'(mem_err), 32'd0);
        check("mw_count", 32'(stall_cycles), 32'd3);
        @(negedge clk); clear_inputs();

        // Timeout: ready held low.
        do_reset();
        dmem_req_m = 1'b1; dmem_ready_m = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) @(negedge clk);
            #1;
            check($sformatf("to_c%0d_memerr", i), 32'(mem_err), (i == 5) ? 32'd1 : 32'd0);
            check($sformatf("to_c%0d_ctl", i), 32'(ctl), 32'(CTL_MEM));
        end
        @(negedge clk);
        dmem_req_m = 1'b0; reg_write_en_w = 1'b1; rd_w = 5'd4; rs2_e = 5'd4; #1;
        check("err_held_ctl", 32'(ctl), 32'(CTL_MEM));
        check("err_fwd_b", 32'(forward_b_e), 32'(FWD_WB));
        @(negedge clk); dmem_ready_m = 1'b1; #1;
        check("err_ready_ctl", 32'(ctl), 32'(CTL_MEM));
        #1 rst = 1'b0;
        #1;
        check("err_rst_ctl", 32'(ctl), 32'(CTL_NONE));
        check("err_rst_fwd_b", 32'(forward_b_e), 32'(FWD_RF));
        check("err_rst_memerr", 32'(mem_err), 32'd0);
        check("err_rst_count", 32'(stall_cycles), 32'd0);
        @(negedge clk); clear_inputs(); rst = 1'b1; #1;
        check("post_rst_state", 32'(dut.state_q), 32'(RUN));
        check("post_rst_ctl", 32'(ctl), 32'(CTL_NONE));

        // Counter saturation at 4 bits.
        do_reset();
        mem_read_en_e = 1'b1; rd_e = 5'd3; rs2_d = 5'd3;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 14) check("sat_count_14", 32'(stall_cycles), 32'd14);
            if (i == 15) check("sat_count_15", 32'(stall_cycles), 32'd15);
        end
        check("sat_count_20", 32'(stall_cycles), 32'd15);
        @(negedge clk); clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
